// File: rtl/branch_resolve_seq.sv
// Sequential RV32I branch comparator: resolves one chunk per cycle, MSB first.
// Define BRCMP_EARLY_EXIT_EN to finish on the first differing chunk.
module branch_resolve_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_rs1,
    input  logic [DATA_WIDTH-1:0] i_rs2,
    input  logic [2:0]            i_funct3,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_taken,
    output logic                  o_breq,
    output logic                  o_brlt,
    output logic                  o_illegal
);

    localparam int N  = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [DATA_WIDTH-1:0] MSB_BIT =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [2:0]            f3;
    logic [IW-1:0]         idx;
    logic                  resolved;
    logic                  lt;

    logic [CHUNK_WIDTH-1:0] ca;
    logic [CHUNK_WIDTH-1:0] cb;
    logic                   diff;
    logic                   early;
    logic [DATA_WIDTH-1:0]  flip;
    logic                   taken;

    // Operands shift left each cycle so the active chunk is always on top.
    assign ca   = a[DATA_WIDTH-1 -: CHUNK_WIDTH];
    assign cb   = b[DATA_WIDTH-1 -: CHUNK_WIDTH];
    assign diff = (ca != cb);
    assign flip = i_funct3[1] ? '0 : MSB_BIT;

`ifdef BRCMP_EARLY_EXIT_EN
    assign early = !resolved && diff;
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            f3       <= '0;
            idx      <= '0;
            resolved <= 1'b0;
            lt       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        a        <= i_rs1 ^ flip;
                        b        <= i_rs2 ^ flip;
                        f3       <= i_funct3;
                        idx      <= IW'(N - 1);
                        resolved <= 1'b0;
                        lt       <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!resolved && diff) begin
                        resolved <= 1'b1;
                        lt       <= (ca < cb);
                    end
                    a <= a << CHUNK_WIDTH;
                    b <= b << CHUNK_WIDTH;
                    if (idx == '0 || early) begin
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000:         taken = !resolved;
            3'b001:         taken = resolved;
            3'b100, 3'b110: taken = lt;
            3'b101, 3'b111: taken = !lt;
            default:        taken = 1'b0;
        endcase
    end

    assign o_ready   = (state == IDLE);
    assign o_valid   = (state == DONE);
    assign o_taken   = o_valid && taken;
    assign o_breq    = o_valid && !resolved;
    assign o_brlt    = o_valid && lt;
    assign o_illegal = o_valid && (f3[2:1] == 2'b01);

endmodule

// File: tb/tb_branch_resolve_seq.sv
// Testbench for branch_resolve_seq: directed cases plus random requests
// checked against an arithmetic reference model.
module tb_branch_resolve_seq;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int N  = DW / CW;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_rs1;
    logic [DW-1:0] i_rs2;
    logic [2:0]    i_funct3;
    logic          o_valid;
    logic          i_ready;
    logic          o_taken;
    logic          o_breq;
    logic          o_brlt;
    logic          o_illegal;

    int errors = 0;
    int checks = 0;

    branch_resolve_seq #(
        .DATA_WIDTH (DW),
        .CHUNK_WIDTH(CW)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_funct3 (i_funct3),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_taken  (o_taken),
        .o_breq   (o_breq),
        .o_brlt   (o_brlt),
        .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference: branch semantics straight from the ISA rules.
    task automatic model(input  logic [DW-1:0] rs1,
                         input  logic [DW-1:0] rs2,
                         input  logic [2:0]    f3,
                         output logic          eq,
                         output logic          lt,
                         output logic          taken,
                         output logic          ill,
                         output int            lat);
        int first;
        eq  = (rs1 == rs2);
        lt  = f3[1] ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3)
            3'b000:         taken = eq;
            3'b001:         taken = !eq;
            3'b100, 3'b110: taken = lt;
            3'b101, 3'b111: taken = !lt;
            default:        taken = 1'b0;
        endcase
        first = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (first < 0 &&
                ((rs1 >> (i * CW)) & 8'hFF) != ((rs2 >> (i * CW)) & 8'hFF))
                first = i;
        end
`ifdef BRCMP_EARLY_EXIT_EN
        lat = (first < 0) ? N + 1 : (N - first) + 1;
`else
        lat = N + 1;
`endif
    endtask

    task automatic run_req(input string         tag,
                           input logic [DW-1:0] rs1,
                           input logic [DW-1:0] rs2,
                           input logic [2:0]    f3,
                           input int            hold);
        logic eq, lt, tk, ill;
        int   elat, lat;
        model(rs1, rs2, f3, eq, lt, tk, ill, elat);
        chk({tag, "_ready"}, o_ready, 1);
        i_rs1    = rs1;
        i_rs2    = rs2;
        i_funct3 = f3;
        i_valid  = 1'b1;
        i_ready  = 1'b0;
        tick();
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 40) begin
            chk({tag, "_busy_ready"}, o_ready, 0);
            chk({tag, "_busy_taken"}, o_taken, 0);
            i_rs1    = $urandom;
            i_funct3 = 3'($urandom);
            i_valid  = 1'($urandom);
            i_ready  = 1'($urandom);
            tick();
            lat++;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk({tag, "_latency"}, lat, elat);
        for (int h = 0; h <= hold; h++) begin
            chk({tag, "_valid"},   o_valid,   1);
            chk({tag, "_taken"},   o_taken,   tk);
            chk({tag, "_breq"},    o_breq,    eq);
            chk({tag, "_brlt"},    o_brlt,    lt);
            chk({tag, "_illegal"}, o_illegal, ill);
            chk({tag, "_dready"},  o_ready,   0);
            if (h < hold) begin
                i_rs1   = $urandom;
                i_valid = 1'($urandom);
                tick();
                i_valid = 1'b0;
            end
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk({tag, "_ret_ready"}, o_ready, 1);
        chk({tag, "_ret_valid"}, o_valid, 0);
    endtask

    initial begin
        logic [DW-1:0] r1, r2;
        i_rst    = 1'b1;
        i_valid  = 1'b1;
        i_ready  = 1'b0;
        i_rs1    = 32'h1;
        i_rs2    = 32'h2;
        i_funct3 = 3'b000;
        tick();
        tick();
        i_rst   = 1'b0;
        i_valid = 1'b0;
        chk("rst_ready",   o_ready,   1);
        chk("rst_valid",   o_valid,   0);
        chk("rst_taken",   o_taken,   0);
        chk("rst_breq",    o_breq,    0);
        chk("rst_brlt",    o_brlt,    0);
        chk("rst_illegal", o_illegal, 0);

        run_req("beq_eq",  32'h1234_5678, 32'h1234_5678, 3'b000, 0);
        run_req("blt_neg", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0);
        run_req("bltu_big", 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0);
        run_req("bgeu_big", 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 0);
        run_req("bltu_msb", 32'h0000_0000, 32'h8000_0000, 3'b110, 0);
        run_req("bne_lsb", 32'hAABB_CC01, 32'hAABB_CC02, 3'b001, 0);
        run_req("hold3",   32'h0000_0010, 32'h8000_0000, 3'b101, 3);
        run_req("illegal", 32'd5, 32'd5, 3'b010, 0);
        run_req("ill011",  32'h7000_0000, 32'h0000_0001, 3'b011, 1);

        // Reset in the second BUSY cycle drops the request.
        i_rs1    = 32'h5555_5555;
        i_rs2    = 32'h5555_5555;
        i_funct3 = 3'b000;
        i_valid  = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("rbusy_ready", o_ready, 1);
        chk("rbusy_valid", o_valid, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rbusy_nopulse", o_valid, 0);
        end

        // Reset while DONE, with a handshake pending on the same edge.
        i_rs1   = 32'h1;
        i_rs2   = 32'h2;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < N; i++) tick();
        chk("rdone_valid_pre", o_valid, 1);
        i_rst   = 1'b1;
        i_ready = 1'b1;
        i_valid = 1'b1;
        tick();
        i_rst   = 1'b0;
        i_ready = 1'b0;
        i_valid = 1'b0;
        chk("rdone_ready", o_ready, 1);
        chk("rdone_valid", o_valid, 0);
        chk("rdone_taken", o_taken, 0);

        for (int n = 0; n < 60; n++) begin
            r1 = $urandom;
            r2 = $urandom;
            case ($urandom_range(0, 3))
                0: r2 = r1;
                1: r2 = {r1[31:8], r2[7:0]};
                2: r2 = {r1[31:16], r2[15:0]};
                default: ;
            endcase
            run_req("rand", r1, r2, 3'($urandom), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
